exu_dispatch: RTL
=================

// Module: exu_dispatch
// PURPOSE
//  Issue side of the execute-unit start/done protocol. Accepts one decoded op from decode
//  (valid/ready), drives a one-cycle fu_start pulse with operands/op_mode to the unit picked
//  by use_part, then waits for that unit's done. It captures the unit's result in the done
//  cycle and holds it for writeback (valid/ready). Sits between decode and the FU bank (ALU/SHIFT/MULDIV/LSU).
// PARAMETERS
//  XLEN            32   operand/result width
//  NUM_FU          4    number of functional units on fu_done/fu_res
//  SHAMT_W         5    shift-amount bits forwarded to SHIFT unit
//  TIMEOUT_CYCLES  16   WAIT cycles before timeout (only with EXU_TIMEOUT_EN)
// PORTS
//  clk        in   1            clock, all state on posedge
//  rst        in   1            asynchronous, active-high reset
//  id_valid   in   1            decode op valid
//  id_ready   out  1            dispatcher can accept (high only in IDLE)
//  id_part    in   2            target FU index (use_part)
//  id_mode1   in   2            op_mode1 (funct7-derived)
//  id_mode2   in   3            op_mode2 (funct3-derived)
//  id_op1     in   XLEN         rs1 value
//  id_op2     in   XLEN         rs2 value / immediate
//  id_rd      in   5            destination register
//  flush      in   1            abandon in-flight op
//  fu_start   out  1            one-cycle start pulse
//  fu_use_part out 2            latched id_part
//  fu_op_mode1 out 2            latched id_mode1
//  fu_op_mode2 out 3            latched id_mode2
//  fu_op1     out  XLEN         latched op1
//  fu_op2     out  XLEN         latched op2, masked for SHIFT (see below)
//  fu_done    in   NUM_FU       per-unit done, one cycle high
//  fu_res     in   NUM_FU*XLEN  per-unit result, slice i = unit i, valid only while fu_done[i]
//  wb_valid   out  1            writeback data valid
//  wb_ready   in   1            writeback accepts
//  wb_rd      out  5            destination register
//  wb_data    out  XLEN         captured result
//  err        out  1            timeout sticky flag (EXU_TIMEOUT_EN only, else tied 0)
// BEHAVIOUR
//  Reset (async): state=IDLE; every output 0 except id_ready=1 once reset releases.
//  FSM IDLE->ISSUE->WAIT->WB->IDLE.
//   IDLE : id_ready=1; on id_valid latch all id_* and go ISSUE.
//   ISSUE: fu_start=1 for exactly one cycle; go WAIT. fu_* stay stable ISSUE..WAIT.
//   WAIT : fu_start=0; when fu_done[part]=1, capture fu_res slice into wb_data and go WB.
//          fu_done of other units and any done seen in ISSUE are ignored.
//   WB   : wb_valid=1 with stable wb_rd/wb_data until wb_ready; then IDLE. No accept in WB.
//  Latency: accept cycle T -> start T+1 -> 1-cycle unit done T+2 -> wb_valid T+3.
//  Throughput: max one op per 4 cycles.
//  fu_op2: if part==FU_SHIFT, bits [XLEN-1:SHAMT_W] forced to 0; otherwise passed unchanged.
//  flush: from any state go IDLE next cycle; wb_valid/fu_start drop to 0, result discarded.
//   flush wins over a same-cycle fu_done or wb_ready. flush in IDLE with id_valid blocks the accept.
//  fu_* outputs return to 0 in IDLE, so FUs see start=0 and clear their outputs.
//  Reset mid-operation: immediate IDLE, any pending result lost.
// CONFIGURATION
//  EXU_TIMEOUT_EN defined: a counter runs in WAIT. After TIMEOUT_CYCLES cycles with no done:
//   set err (sticky until rst) and go WB with wb_data=0, so the pipeline does not hang.
//   A done on the final count cycle wins over the timeout.
//  Not defined: no counter, WAIT has no exit except done or flush, err tied 0.
// STRUCTURE
//  Shared header rv_exu_defs.vh holds:
//   FU indices FU_ALU=0, FU_SHIFT=1, FU_MULDIV=2, FU_LSU=3
//   op_mode1/op_mode2 encodings (SLL 00/000, SRL 00/010, SRA 00/100, SLLI 10/000, SRLI 10/010)
//   FSM state encoding
//  Sub-module exu_res_sel: combinational NUM_FU-way mux, selects done bit and result slice by part.
// TESTING
//  SHIFT SLL, op1=0x0000_0001, op2=0xFFFF_FFE4 -> fu_op2=0x4; wb_data=0x10 at T+3; rd echoed.
//  wb_ready=0 for 5 cycles in WB -> wb_valid/wb_data held, id_ready=0; accept 1 cycle after release.
//  Back-to-back id_valid -> second op accepted only in IDLE; exactly one fu_start per op.
//  flush in WAIT coincident with fu_done -> no wb_valid, IDLE next cycle.
//  fu_done[ALU] pulse while part=SHIFT -> ignored; still waits for fu_done[SHIFT].
//  EXU_TIMEOUT_EN, no done for 16 cycles -> err=1, wb_valid with wb_data=0; rst mid-WAIT -> all outputs 0.

Source files
------------

// File: rtl/exu_dispatch_pkg.sv
// Shared encodings for the execute-unit dispatcher: FU indices, op_mode values, FSM states.
package exu_dispatch_pkg;

    typedef enum logic [1:0] {
        FU_ALU    = 2'd0,
        FU_SHIFT  = 2'd1,
        FU_MULDIV = 2'd2,
        FU_LSU    = 2'd3
    } fu_part_e;

    localparam logic [1:0] MODE1_SHIFT_REG = 2'b00;
    localparam logic [1:0] MODE1_SHIFT_IMM = 2'b10;
    localparam logic [2:0] MODE2_SLL       = 3'b000;
    localparam logic [2:0] MODE2_SRL       = 3'b010;
    localparam logic [2:0] MODE2_SRA       = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } exu_state_e;

endpackage

// File: rtl/exu_res_sel.sv
// NUM_FU-way selector: picks the done bit and result slice of the unit addressed by part.
module exu_res_sel #(
    parameter int XLEN   = 32,
    parameter int NUM_FU = 4,
    parameter int PART_W = 2
) (
    input  logic [PART_W-1:0]      part,
    input  logic [NUM_FU-1:0]      fu_done,
    input  logic [NUM_FU*XLEN-1:0] fu_res,
    output logic                   sel_done,
    output logic [XLEN-1:0]        sel_res
);

    logic hit_s;

    // AND-OR mux over all units; exactly one hit term is ever active
    always_comb begin
        sel_done = 1'b0;
        sel_res  = '0;
        hit_s    = 1'b0;
        for (int i = 0; i < NUM_FU; i++) begin
            hit_s    = (part == PART_W'(i));
            sel_done = sel_done | (fu_done[i] & hit_s);
            sel_res  = sel_res | (fu_res[i*XLEN +: XLEN] & {XLEN{hit_s}});
        end
    end

endmodule

// File: rtl/exu_dispatch.sv
// Execute-unit dispatcher: decode handshake -> fu_start pulse -> wait for done -> writeback.
// Optional WAIT timeout with sticky err is built when EXU_TIMEOUT_EN is defined.
module exu_dispatch
    import exu_dispatch_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int NUM_FU         = 4,
    parameter int SHAMT_W        = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    output logic                   id_ready,
    input  logic [1:0]             id_part,
    input  logic [1:0]             id_mode1,
    input  logic [2:0]             id_mode2,
    input  logic [XLEN-1:0]        id_op1,
    input  logic [XLEN-1:0]        id_op2,
    input  logic [4:0]             id_rd,
    input  logic                   flush,
    output logic                   fu_start,
    output logic [1:0]             fu_use_part,
    output logic [1:0]             fu_op_mode1,
    output logic [2:0]             fu_op_mode2,
    output logic [XLEN-1:0]        fu_op1,
    output logic [XLEN-1:0]        fu_op2,
    input  logic [NUM_FU-1:0]      fu_done,
    input  logic [NUM_FU*XLEN-1:0] fu_res,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [4:0]             wb_rd,
    output logic [XLEN-1:0]        wb_data,
    output logic                   err
);

    exu_state_e      state_r;
    logic            fu_start_r;
    logic [1:0]      part_r;
    logic [1:0]      mode1_r;
    logic [2:0]      mode2_r;
    logic [XLEN-1:0] op1_r;
    logic [XLEN-1:0] op2_r;
    logic [4:0]      rd_r;
    logic            wb_valid_r;
    logic [4:0]      wb_rd_r;
    logic [XLEN-1:0] wb_data_r;
    logic            sel_done_s;
    logic [XLEN-1:0] sel_res_s;
    logic            go_idle_s;
    logic            timeout_s;

    // The SHIFT unit only consumes the shift amount; upper operand bits are cleared
    function automatic logic [XLEN-1:0] shift_mask(input logic [XLEN-1:0] op,
                                                   input logic [1:0]      part);
        logic [XLEN-1:0] m;
        m = op;
        if (part == FU_SHIFT) begin
            m[XLEN-1:SHAMT_W] = '0;
        end else begin
            m = op;
        end
        return m;
    endfunction

    exu_res_sel #(.XLEN(XLEN), .NUM_FU(NUM_FU), .PART_W(2)) u_res_sel (
        .part     (part_r),
        .fu_done  (fu_done),
        .fu_res   (fu_res),
        .sel_done (sel_done_s),
        .sel_res  (sel_res_s)
    );

    assign go_idle_s = flush | ((state_r == ST_WB) & wb_ready);

`ifdef EXU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_r;
    logic             err_r;

    assign timeout_s = (state_r == ST_WAIT) && (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counts cycles spent in WAIT; restarts whenever WAIT is left
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_r <= '0;
        end else if (state_r != ST_WAIT) begin
            wait_cnt_r <= '0;
        end else begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
        end
    end

    // Sticky timeout flag; a same-cycle done or flush suppresses it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (timeout_s && !sel_done_s && !flush) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`else
    assign timeout_s = 1'b0;
    assign err       = 1'b0;
`endif

    // Dispatch FSM with all handshake and FU-side outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst || go_idle_s) begin
            state_r    <= ST_IDLE;
            fu_start_r <= 1'b0;
            part_r     <= 2'd0;
            mode1_r    <= 2'd0;
            mode2_r    <= 3'd0;
            op1_r      <= '0;
            op2_r      <= '0;
            rd_r       <= 5'd0;
            wb_valid_r <= 1'b0;
            wb_rd_r    <= 5'd0;
            wb_data_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (id_valid) begin
                        state_r    <= ST_ISSUE;
                        fu_start_r <= 1'b1;
                        part_r     <= id_part;
                        mode1_r    <= id_mode1;
                        mode2_r    <= id_mode2;
                        op1_r      <= id_op1;
                        op2_r      <= shift_mask(id_op2, id_part);
                        rd_r       <= id_rd;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    state_r    <= ST_WAIT;
                    fu_start_r <= 1'b0;
                end
                ST_WAIT: begin
                    if (sel_done_s) begin
                        state_r    <= ST_WB;
                        wb_valid_r <= 1'b1;
                        wb_rd_r    <= rd_r;
                        wb_data_r  <= sel_res_s;
                    end else if (timeout_s) begin
                        state_r    <= ST_WB;
                        wb_valid_r <= 1'b1;
                        wb_rd_r    <= rd_r;
                        wb_data_r  <= '0;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_WB: begin
                    state_r <= ST_WB;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    fu_start_r <= 1'b0;
                    wb_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Decoded from the state register, so it carries no combinational input path
    assign id_ready    = (state_r == ST_IDLE);
    assign fu_start    = fu_start_r;
    assign fu_use_part = part_r;
    assign fu_op_mode1 = mode1_r;
    assign fu_op_mode2 = mode2_r;
    assign fu_op1      = op1_r;
    assign fu_op2      = op2_r;
    assign wb_valid    = wb_valid_r;
    assign wb_rd       = wb_rd_r;
    assign wb_data     = wb_data_r;

endmodule
